// File: rtl/writeback_arbiter_pkg.sv
// Shared writeback types and default sizing for the writeback arbiter slice.
package writeback_arbiter_pkg;

  localparam int unsigned WB_REQ_NUM   = 5;   // misc, alu0, alu1, mdu, mem
  localparam int unsigned WB_PORT_NUM  = 2;   // equals COMMIT_WIDTH
  localparam int unsigned PHY_REG_NUM  = 64;
  localparam int unsigned ROB_DEPTH    = 32;
  localparam int unsigned WB_PREG_W    = $clog2(PHY_REG_NUM);
  localparam int unsigned WB_ROB_W     = $clog2(ROB_DEPTH) + 1;  // index plus position bit
  localparam int unsigned WB_DATA_W    = 32;

  typedef struct packed {
    logic                 pdest_valid;
    logic [WB_PREG_W-1:0] pdest;
    logic [WB_ROB_W-1:0]  rob_idx;
    logic [WB_DATA_W-1:0] data;
  } WbReqSt;

  typedef struct packed {
    logic                 pdest_valid;
    logic [WB_PREG_W-1:0] pdest;
    logic [WB_ROB_W-1:0]  rob_idx;
    logic [WB_DATA_W-1:0] data;
  } WbPortSt;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Requester-side and writeback-side signals of the writeback arbiter.
interface writeback_arbiter_if #(
  parameter int unsigned REQ_NUM  = writeback_arbiter_pkg::WB_REQ_NUM,
  parameter int unsigned PORT_NUM = writeback_arbiter_pkg::WB_PORT_NUM,
  parameter int unsigned PREG_W   = writeback_arbiter_pkg::WB_PREG_W,
  parameter int unsigned ROB_W    = writeback_arbiter_pkg::WB_ROB_W
);
  logic                             flush_i;
  logic [REQ_NUM-1:0]               req_valid_i;
  logic [REQ_NUM-1:0]               req_ready_o;
  logic [REQ_NUM-1:0]               req_pdest_valid_i;
  logic [REQ_NUM-1:0][PREG_W-1:0]   req_pdest_i;
  logic [REQ_NUM-1:0][ROB_W-1:0]    req_rob_idx_i;
  logic [REQ_NUM-1:0][31:0]         req_data_i;
  logic [PORT_NUM-1:0]              wb_valid_o;
  logic                             wb_ready_i;
  logic [PORT_NUM-1:0]              wb_pdest_valid_o;
  logic [PORT_NUM-1:0][PREG_W-1:0]  wb_pdest_o;
  logic [PORT_NUM-1:0][ROB_W-1:0]   wb_rob_idx_o;
  logic [PORT_NUM-1:0][31:0]        wb_data_o;

  // The arbiter itself.
  modport slave (
    input  flush_i, req_valid_i, req_pdest_valid_i, req_pdest_i, req_rob_idx_i, req_data_i,
    input  wb_ready_i,
    output req_ready_o, wb_valid_o, wb_pdest_valid_o, wb_pdest_o, wb_rob_idx_o, wb_data_o
  );

  // Execution units plus ROB/regfile around the arbiter.
  modport master (
    output flush_i, req_valid_i, req_pdest_valid_i, req_pdest_i, req_rob_idx_i, req_data_i,
    output wb_ready_i,
    input  req_ready_o, wb_valid_o, wb_pdest_valid_o, wb_pdest_o, wb_rob_idx_o, wb_data_o
  );
endinterface

// File: rtl/writeback_arbiter_rr_select.sv
// Rotating-priority pick of the first PORT_NUM set bits of valid, starting at base.
module writeback_arbiter_rr_select #(
  parameter int unsigned REQ_NUM  = 5,
  parameter int unsigned PORT_NUM = 2,
  parameter int unsigned PTR_W    = 3
) (
  input  logic [REQ_NUM-1:0]             valid,
  input  logic [PTR_W-1:0]               base,
  output logic [REQ_NUM-1:0]             grant,
  output logic [PORT_NUM-1:0]            sel_vld,
  output logic [PORT_NUM-1:0][PTR_W-1:0] sel_idx,
  output logic [PTR_W-1:0]               next_ptr
);

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] b, input int unsigned off);
    int unsigned s;
    s = 32'(b) + off;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return PTR_W'(s);
  endfunction

  logic [REQ_NUM-1:0]   rot;
  logic [REQ_NUM-1:0]   grant_rot;
  logic [2*REQ_NUM-1:0] unrot;
  int unsigned          cnt;

  // Rotate so base sits at bit 0, pick with fixed priority, rotate grants back.
  always_comb begin
    rot       = REQ_NUM'({valid, valid} >> base);
    grant_rot = '0;
    sel_vld   = '0;
    sel_idx   = '0;
    next_ptr  = base;
    cnt       = 0;
    for (int unsigned off = 0; off < REQ_NUM; off++) begin
      if (rot[off] && cnt < PORT_NUM) begin
        grant_rot[off] = 1'b1;
        for (int unsigned k = 0; k < PORT_NUM; k++) begin
          if (k == cnt) begin
            sel_vld[k] = 1'b1;
            sel_idx[k] = wrap_add(base, off);
          end
        end
        next_ptr = wrap_add(base, off + 1);
        cnt++;
      end
    end
    unrot = {grant_rot, grant_rot} << base;
    grant = unrot[2*REQ_NUM-1:REQ_NUM];
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates execution-unit results onto PORT_NUM registered writeback/wake-up ports.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM  = WB_REQ_NUM,
  parameter int unsigned PORT_NUM = WB_PORT_NUM,
  parameter int unsigned PREG_W   = WB_PREG_W,
  parameter int unsigned ROB_W    = WB_ROB_W
) (
  input  logic               clk,
  input  logic               a_rst_n,
  writeback_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  logic                             out_free;
  logic                             grant_en;
  logic [PTR_W-1:0]                 rr_ptr;
  logic [PTR_W-1:0]                 next_ptr;
  logic [REQ_NUM-1:0]               grant;
  logic [PORT_NUM-1:0]              sel_vld;
  logic [PORT_NUM-1:0][PTR_W-1:0]   sel_idx;
  WbReqSt  [REQ_NUM-1:0]            req_st;
  WbPortSt [PORT_NUM-1:0]           port_d;
  WbPortSt [PORT_NUM-1:0]           port_q;
  logic [PORT_NUM-1:0]              valid_q;

  assign out_free = ~|valid_q | bus.wb_ready_i;
  // Gating with a_rst_n keeps ready low for the whole reset window.
  assign grant_en = out_free & ~bus.flush_i & a_rst_n;

  writeback_arbiter_rr_select #(
    .REQ_NUM  (REQ_NUM),
    .PORT_NUM (PORT_NUM),
    .PTR_W    (PTR_W)
  ) u_rr_select (
    .valid    (bus.req_valid_i & {REQ_NUM{grant_en}}),
    .base     (rr_ptr),
    .grant    (grant),
    .sel_vld  (sel_vld),
    .sel_idx  (sel_idx),
    .next_ptr (next_ptr)
  );

  assign bus.req_ready_o = grant;

  always_comb begin
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      req_st[i] = '{pdest_valid: bus.req_pdest_valid_i[i],
                    pdest:       bus.req_pdest_i[i],
                    rob_idx:     bus.req_rob_idx_i[i],
                    data:        bus.req_data_i[i]};
    end
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      port_d[k] = '0;
      if (sel_vld[k]) begin
        port_d[k].pdest_valid = req_st[sel_idx[k]].pdest_valid;
        port_d[k].pdest       = req_st[sel_idx[k]].pdest;
        port_d[k].rob_idx     = req_st[sel_idx[k]].rob_idx;
        port_d[k].data        = req_st[sel_idx[k]].data;
      end
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      valid_q <= '0;
      port_q  <= '0;
      rr_ptr  <= '0;
    end else begin
      if (bus.flush_i) begin
        valid_q <= '0;
        for (int unsigned k = 0; k < PORT_NUM; k++) port_q[k].pdest_valid <= 1'b0;
      end else if (out_free) begin
        valid_q <= sel_vld;
        port_q  <= port_d;
      end
      if (|grant) rr_ptr <= next_ptr;
    end
  end

  always_comb begin
    bus.wb_valid_o = valid_q;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      bus.wb_pdest_valid_o[k] = port_q[k].pdest_valid;
      bus.wb_pdest_o[k]       = port_q[k].pdest;
      bus.wb_rob_idx_o[k]     = port_q[k].rob_idx;
      bus.wb_data_o[k]        = port_q[k].data;
    end
  end

endmodule
